rf_multiport_sb: RTL
====================

// Module: rf_multiport_sb
// PURPOSE
// - Parametrised successor register file for the pipelined CPU: NRD async read ports, NWR sync write ports.
// - Adds a pending-write scoreboard so decode can detect RAW hazards on in-flight destinations.
// - Sits between decode (read, issue), writeback (write, clear) and hazard unit (busy flags).
// PARAMETERS
// - DW       32          data width
// - AW       5           address width; DEPTH = 2**AW registers
// - NRD      2           read ports
// - NWR      1           write ports (1..2)
// - GP_INIT  32'h1800    reset value of register 28
// - SP_INIT  32'h2ffc    reset value of register 29
// PORTS
// - clk        in   1        clock, all state updates on posedge
// - rst_n      in   1        reset, asynchronous, active-high
// - ra_i       in   NRD*AW   read addresses, port k = ra_i[k*AW +: AW]
// - rd_o       out  NRD*DW   read data, port k = rd_o[k*DW +: DW]
// - busy_o     out  NRD      port k address has pending write
// - we_i       in   NWR      write enable per write port
// - wa_i       in   NWR*AW   write addresses
// - wd_i       in   NWR*DW   write data
// - iss_i      in   1        issue: mark iss_addr_i pending
// - iss_addr_i in   AW       destination of issued instruction
// - sb_full_o  out  1        all DEPTH-1 writable registers pending
// BEHAVIOUR
// - Reset (async, rst_n=1): reg28=GP_INIT, reg29=SP_INIT, all others 0; all pending bits 0.
// - Outputs under reset: rd_o = reset contents of addressed regs, busy_o=0, sb_full_o=0.
// - Reads combinational, zero latency; reg 0 always reads 0, busy for reg 0 always 0.
// - Write: posedge clk, we_i[j]=1 and wa_i[j]!=0 -> reg[wa_i[j]] <= wd_i[j]; writes to 0 ignored.
// - Two write ports same address same cycle: higher port index wins (data and clear).
// - Scoreboard per reg: pending <= (pending & ~clr) | set.
//   - clr: any enabled write port targets reg; set: iss_i=1 and iss_addr_i targets reg (nonzero).
//   - Issue and writeback same reg same cycle: set wins, pending stays 1 (newer producer).
// - busy_o[k] = pending[ra_i[k]] (registered state, before this cycle's clr/set) unless bypass.
// - sb_full_o = &pending[DEPTH-1:1]; iss_i while full is legal, no state change beyond clr.
// - Reset mid-operation: all pending cleared, in-flight writes that cycle discarded.
// CONFIGURATION
// - RF_BYPASS_EN defined: write-to-read forwarding; if we_i[j], wa_i[j]==ra_i[k]!=0,
//   rd_o[k]=wd_i[j] (highest j wins) and busy_o[k]=0 unless iss_i same addr same cycle.
// - RF_BYPASS_EN undefined: rd_o/busy_o reflect stored state only; new value visible next cycle.
// STRUCTURE
// - Package rf_pkg: REG_ZERO=0, REG_GP=28, REG_SP=29, GP_INIT/SP_INIT default constants.
// - Sub-module rf_scoreboard: pending vector, set/clear priority, busy lookup, full flag.
// - Top: storage array, write-port priority mux, read muxes, optional bypass.
// TESTING
// - Reset: pulse rst_n mid-write -> ra=28 reads 32'h1800, ra=29 reads 32'h2ffc, busy_o=0.
// - Write reg 0: we=1 wa=0 wd=32'hdead_beef -> ra=0 reads 0 next cycle.
// - Issue ra=5, next cycle busy_o=1; write reg5=32'h1234 -> after clk busy_o=0, rd_o=32'h1234.
// - Same-cycle iss_addr=7 and write wa=7 -> reg7 updated, busy stays 1.
// - NWR=2 both ports wa=9, wd 32'h1 / 32'h2 -> reg9=32'h2.
// - With RF_BYPASS_EN: write wa=3 wd=32'h55 while ra=3 -> rd_o=32'h55 same cycle; without: old value.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants for the multiport register file.
//   REG_ZERO / REG_GP / REG_SP : architectural register indices
//   GP_INIT_D / SP_INIT_D      : default reset contents of GP and SP
package rf_pkg;
  localparam int          REG_ZERO  = 0;
  localparam int          REG_GP    = 28;
  localparam int          REG_SP    = 29;
  localparam logic [31:0] GP_INIT_D = 32'h1800;
  localparam logic [31:0] SP_INIT_D = 32'h2ffc;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one pending bit per register. An issue marks a register as
// having an in-flight producer; a writeback to it clears the bit.
//   clk, rst_n  : clock, asynchronous active-high reset
//   ra_i        : NRD packed read addresses
//   we_i/wa_i   : writeback enables / addresses (clear sources)
//   iss_i/iss_addr_i : issue strobe / destination (set source)
//   busy_o      : pending bit of each read port's register (stored state)
//   sb_full_o   : every writable register (1..DEPTH-1) is pending
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW  = 5,
  parameter int NRD = 2,
  parameter int NWR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] ra_i,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] wa_i,
  input  logic              iss_i,
  input  logic [AW-1:0]     iss_addr_i,
  output logic [NRD-1:0]    busy_o,
  output logic              sb_full_o
);
  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] set_v;
  logic [DEPTH-1:0] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int j = 0; j < NWR; j++)
      if (we_i[j] && wa_i[j*AW +: AW] != '0) clr_v[wa_i[j*AW +: AW]] = 1'b1;
    if (iss_i && iss_addr_i != '0) set_v[iss_addr_i] = 1'b1;
  end

  // set applied after clear: an issue racing a writeback to the same register
  // belongs to a newer producer, so the register stays pending.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) pending <= '0;
    else       pending <= ((pending & ~clr_v) | set_v) & ~DEPTH'(1);
  end

  always_comb begin
    busy_o = '0;
    for (int k = 0; k < NRD; k++) busy_o[k] = pending[ra_i[k*AW +: AW]];
  end

  assign sb_full_o = &pending[DEPTH-1:1];
endmodule

// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb: register file with NRD combinational read ports, NWR
// synchronous write ports and a pending-write scoreboard for RAW detection.
//   clk, rst_n      : clock, asynchronous active-high reset
//   ra_i / rd_o     : read addresses / data, port k at [k*AW +: AW] / [k*DW +: DW]
//   busy_o          : read port k's register has an in-flight producer
//   we_i/wa_i/wd_i  : write ports; higher index wins on address collision
//   iss_i/iss_addr_i: mark destination pending
//   sb_full_o       : all writable registers pending
// Optional build macro RF_BYPASS_EN: forward same-cycle write data to reads.
module rf_multiport_sb
  import rf_pkg::*;
#(
  parameter int          DW      = 32,
  parameter int          AW      = 5,
  parameter int          NRD     = 2,
  parameter int          NWR     = 1,
  parameter logic [DW-1:0] GP_INIT = DW'(GP_INIT_D),
  parameter logic [DW-1:0] SP_INIT = DW'(SP_INIT_D)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] ra_i,
  output logic [NRD*DW-1:0] rd_o,
  output logic [NRD-1:0]    busy_o,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] wa_i,
  input  logic [NWR*DW-1:0] wd_i,
  input  logic              iss_i,
  input  logic [AW-1:0]     iss_addr_i,
  output logic              sb_full_o
);
  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0][DW-1:0] regs;
  logic [NRD-1:0]           sb_busy;
  logic [NRD-1:0][DW-1:0]   rd_arr;

  rf_scoreboard #(.AW(AW), .NRD(NRD), .NWR(NWR)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_i       (ra_i),
    .we_i       (we_i),
    .wa_i       (wa_i),
    .iss_i      (iss_i),
    .iss_addr_i (iss_addr_i),
    .busy_o     (sb_busy),
    .sb_full_o  (sb_full_o)
  );

  // Ports are visited in ascending order, so the last (highest) port's
  // non-blocking assignment wins a same-address collision. Register 0 is
  // never written and keeps its reset value of zero.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= (i == REG_GP) ? GP_INIT : (i == REG_SP) ? SP_INIT : '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (we_i[j] && wa_i[j*AW +: AW] != '0)
          regs[wa_i[j*AW +: AW]] <= wd_i[j*DW +: DW];
    end
  end

  always_comb begin
    rd_arr = '0;
    busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_arr[k] = regs[ra_i[k*AW +: AW]];
      busy_o[k] = sb_busy[k];
`ifdef RF_BYPASS_EN
      // Forwarding is suppressed under reset, where writes are discarded.
      // A same-cycle issue to the read address still reports busy, since a
      // newer producer supersedes the value being forwarded.
      for (int j = 0; j < NWR; j++) begin
        if (!rst_n && we_i[j] && ra_i[k*AW +: AW] != '0 &&
            wa_i[j*AW +: AW] == ra_i[k*AW +: AW]) begin
          rd_arr[k] = wd_i[j*DW +: DW];
          busy_o[k] = iss_i && (iss_addr_i == ra_i[k*AW +: AW]);
        end
      end
`endif
    end
  end

  assign rd_o = rd_arr;
endmodule
